demux_2s: RTL and testbench
===========================

DEMUX_2S -- requirements
Module: demux_2s

Interface
REQ-001 SHALL have parameter: w, 4, data width of the input word and each output channel.
REQ-002 SHALL have ports, one per line:
  clk  input  1  single clock; all state on rising edge
  rst_n  input  1  reset, asynchronous and active-low
  d  input  w  input data word
  s  input  2  destination select (0..3), sampled with d
  in_valid  input  1  d/s valid
  in_ready  output  1  block can accept d this cycle
  o0, o1, o2, o3  output  w each  channel data from holding registers
  o_valid  output  4  bit i = channel i holds unread word
  o_ready  input  4  bit i = consumer of channel i takes word
  cnt  output  8  accepted-word count (only with DEMUX_CNT_EN)

Function
REQ-003 SHALL implement a 1-to-4 demultiplexer (inverse of the 4:1 select mux); each channel i has a one-entry holding register buf_i and a flag full_i.
REQ-004 Each channel SHALL run a two-state machine, EMPTY (full_i=0) and FULL (full_i=1); o_valid[i] = full_i; o_i = buf_i at all times.
REQ-005 in_ready SHALL be combinational: !full_s || o_ready[s], where s is the current select; no dependence on in_valid.
REQ-006 Accept SHALL occur on a rising edge with in_valid && in_ready: buf_s <= d, full_s <= 1; other channels unchanged.
REQ-007 Latency SHALL be one cycle: a word accepted on edge N appears with o_valid[s]=1 after edge N.
REQ-008 Drain SHALL occur on channel i at an edge with o_valid[i] && o_ready[i]: FULL->EMPTY unless a same-edge accept targets i.
REQ-009 Simultaneous drain and accept on the same channel SHALL keep full_i=1 and load the new d (back-to-back, full throughput per channel).
REQ-010 Channels SHALL drain independently; drains on several channels in one cycle are all honoured.
REQ-011 Accept into channel i SHALL not disturb any other channel's data or flag.
REQ-012 When full_s=1 and o_ready[s]=0, in_ready SHALL be 0 and d SHALL be ignored (no overwrite, no loss).
REQ-013 On EMPTY, o_i SHALL hold the last stored word (0 after reset); consumers use o_valid only.
REQ-014 in_valid with in_ready=0 SHALL not change any state; s may change while stalled and in_ready SHALL follow it.

Reset
REQ-015 rst_n low SHALL asynchronously clear all full_i, o_valid=4'b0000, all buf_i/o_i=0, cnt=0.
REQ-016 Reset asserted mid-operation SHALL discard buffered words; no o_valid pulse after release until a new accept.
REQ-017 After rst_n rises, in_ready SHALL be 1 for any s.

Configuration
REQ-018 Macro DEMUX_CNT_EN defined: port cnt exists; cnt increments by 1 on every accept, wraps 255->0; unchanged otherwise.
REQ-019 Macro DEMUX_CNT_EN undefined: port cnt and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-020 Reset, then d=4'b0001,s=0; d=4'b0010,s=1; d=4'b0100,s=2; d=4'b1000,s=3, o_ready=0 -> o_valid=4'b1111, o0..o3=0001,0010,0100,1000, then in_ready=0 for all s.
REQ-021 Channel 2 full (0100), o_ready=0, in_valid with d=4'b1111,s=2 for 3 cycles -> in_ready=0, o2 stays 0100; raise o_ready[2] -> 1111 loaded on that edge, o_valid[2] stays 1.
REQ-022 o_ready=4'b1111, stream d=1..8 with s=1 every cycle -> in_ready constant 1, o1 shows each word one cycle later, o_valid[1]=1 continuously, others 0.
REQ-023 All four channels full, o_ready=4'b0101 for one cycle -> o_valid=4'b1010 next cycle, o1/o3 unchanged.
REQ-024 Two channels full, assert rst_n=0 between edges -> o_valid=0, o0..o3=0 immediately; after release in_ready=1, no o_valid until new accept.
REQ-025 With DEMUX_CNT_EN, 260 accepts -> cnt=4; stalled cycles do not count.

Source files
------------

// File: rtl/demux_2s.sv
// demux_2s: 1-to-4 demultiplexer with a one-entry holding register per channel.
// A word on d is steered to channel s; each channel holds it until its consumer
// takes it via o_ready. in_ready only looks at the selected channel, so a busy
// channel never blocks traffic to the others.
// Optional feature: define DEMUX_CNT_EN to add the 8-bit accepted-word counter cnt.

// One output channel: EMPTY/FULL machine plus its holding register.
module demux_2s_ch #(
   parameter int w = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         drain,
   input  logic [w-1:0] d,
   output logic [w-1:0] data,
   output logic         full
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t state, state_nxt;

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= EMPTY;
      else        state <= state_nxt;
   end

   // next state: a load on the same edge as a drain keeps the channel full
   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY:   if (load) state_nxt = FULL;
         FULL:    if (drain && !load) state_nxt = EMPTY;
         default: state_nxt = EMPTY;
      endcase
   end

   // holding register keeps the last word after a drain; only a load replaces it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    data <= '0;
      else if (load) data <= d;
   end

   assign full = (state == FULL);

endmodule

// Top level: select decode, ready logic and the four channels.
module demux_2s #(
   parameter int w = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [w-1:0] d,
   input  logic [1:0]   s,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [w-1:0] o0,
   output logic [w-1:0] o1,
   output logic [w-1:0] o2,
   output logic [w-1:0] o3,
   output logic [3:0]   o_valid,
   input  logic [3:0]   o_ready
`ifdef DEMUX_CNT_EN
   ,
   output logic [7:0]   cnt
`endif
);

   logic [3:0]          full;
   logic [3:0]          load;
   logic [3:0]          drain;
   logic [3:0][w-1:0]   data;
   logic                accept;

   // selected channel can take a word if empty or being drained this edge
   assign in_ready = !full[s] || o_ready[s];
   assign accept   = in_valid && in_ready;
   assign drain    = full & o_ready;
   assign o_valid  = full;

   genvar i;
   generate
      for (i = 0; i < 4; i++) begin : g_ch
         assign load[i] = accept && (s == 2'(i));

         demux_2s_ch #(.w(w)) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load[i]),
            .drain (drain[i]),
            .d     (d),
            .data  (data[i]),
            .full  (full[i])
         );
      end
   endgenerate

   assign o0 = data[0];
   assign o1 = data[1];
   assign o2 = data[2];
   assign o3 = data[3];

`ifdef DEMUX_CNT_EN
   // accepted-word counter, wraps naturally at 8 bits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      cnt <= 8'd0;
      else if (accept) cnt <= cnt + 8'd1;
   end
`endif

endmodule

// File: tb/tb_demux_2s.sv
// Bench for demux_2s: per-channel scoreboard queues of expected words plus a
// flag model for the full bits; directed scenarios followed by random traffic.
module tb_demux_2s;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] d;
   logic [1:0]   s;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] o0, o1, o2, o3;
   logic [3:0]   o_valid;
   logic [3:0]   o_ready;
`ifdef DEMUX_CNT_EN
   logic [7:0]   cnt;
   logic [7:0]   cnt_m;
`endif

   int n_cmp = 0;
   int n_err = 0;

   logic [3:0]   mf;
   logic [W-1:0] exp_q[4][$];

   demux_2s #(.w(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .d        (d),
      .s        (s),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .o0       (o0),
      .o1       (o1),
      .o2       (o2),
      .o3       (o3),
      .o_valid  (o_valid),
      .o_ready  (o_ready)
`ifdef DEMUX_CNT_EN
      ,
      .cnt      (cnt)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] o_at(input int i);
      case (i)
         0:       return o0;
         1:       return o1;
         2:       return o2;
         default: return o3;
      endcase
   endfunction

   // one clock with inputs already applied: check ready, score drains/accepts,
   // then check flags and data after the edge
   task automatic cycle();
      logic         exp_rdy, acc;
      logic [3:0]   drn;
      logic [W-1:0] front;
      #1;
      exp_rdy = !mf[s] || o_ready[s];
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      acc = in_valid && exp_rdy;
      drn = mf & o_ready;
      for (int i = 0; i < 4; i++) begin
         if (drn[i] && exp_q[i].size() > 0) begin
            front = exp_q[i].pop_front();
            chk("drain_data", 32'(o_at(i)), 32'(front));
         end
      end
      if (acc) exp_q[s].push_back(d);
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++)
         mf[i] = (mf[i] && !drn[i]) || (acc && s == 2'(i));
      chk("o_valid", 32'(o_valid), 32'(mf));
      for (int i = 0; i < 4; i++)
         if (mf[i] && exp_q[i].size() > 0)
            chk("o_data", 32'(o_at(i)), 32'(exp_q[i][0]));
`ifdef DEMUX_CNT_EN
      if (acc) cnt_m = cnt_m + 8'd1;
      chk("cnt", 32'(cnt), 32'(cnt_m));
`endif
   endtask

   task automatic drive(input logic v, input logic [1:0] ss, input logic [W-1:0] dd,
                        input logic [3:0] rdy);
      in_valid = v;
      s        = ss;
      d        = dd;
      o_ready  = rdy;
      cycle();
   endtask

   task automatic clear_model();
      mf = 4'b0000;
      for (int i = 0; i < 4; i++) exp_q[i].delete();
`ifdef DEMUX_CNT_EN
      cnt_m = 8'd0;
`endif
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_o_valid"}, 32'(o_valid), 32'h0);
      chk({tag, "_o0"}, 32'(o0), 32'h0);
      chk({tag, "_o1"}, 32'(o1), 32'h0);
      chk({tag, "_o2"}, 32'(o2), 32'h0);
      chk({tag, "_o3"}, 32'(o3), 32'h0);
`ifdef DEMUX_CNT_EN
      chk({tag, "_cnt"}, 32'(cnt), 32'h0);
`endif
   endtask

   task automatic check_ready_all_s(input string tag, input logic exp);
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         s = 2'(k);
         #1;
         chk(tag, 32'(in_ready), 32'(exp));
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      s        = 2'd0;
      d        = '0;
      o_ready  = 4'b0000;
      clear_model();
      #1;
      check_reset_state("reset");
      #12;
      rst_n = 1'b1;
      check_ready_all_s("ready_after_reset", 1'b1);
      @(posedge clk);
      #1;

      // fill all four channels with consumers stalled
      drive(1'b1, 2'd0, 4'b0001, 4'b0000);
      drive(1'b1, 2'd1, 4'b0010, 4'b0000);
      drive(1'b1, 2'd2, 4'b0100, 4'b0000);
      drive(1'b1, 2'd3, 4'b1000, 4'b0000);
      chk("fill_o_valid", 32'(o_valid), 32'hf);
      chk("fill_o0", 32'(o0), 32'b0001);
      chk("fill_o1", 32'(o1), 32'b0010);
      chk("fill_o2", 32'(o2), 32'b0100);
      chk("fill_o3", 32'(o3), 32'b1000);
      check_ready_all_s("ready_when_full", 1'b0);
      @(posedge clk);
      #1;

      // stalled write to full channel 2 is ignored, then loads with a drain
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 2'd2, 4'b1111, 4'b0000);
         chk("stall_o2_hold", 32'(o2), 32'b0100);
      end
      drive(1'b1, 2'd2, 4'b1111, 4'b0100);
      chk("pass_o2_load", 32'(o2), 32'b1111);
      chk("pass_o_valid2", 32'(o_valid[2]), 32'h1);

      // independent drains on channels 0 and 2
      drive(1'b0, 2'd0, 4'b0000, 4'b0101);
      chk("part_o_valid", 32'(o_valid), 32'b1010);
      chk("part_o1", 32'(o1), 32'b0010);
      chk("part_o3", 32'(o3), 32'b1000);
      drive(1'b0, 2'd0, 4'b0000, 4'b1111);
      chk("all_drained", 32'(o_valid), 32'h0);

      // full-throughput stream into channel 1
      for (int k = 1; k <= 8; k++) begin
         drive(1'b1, 2'd1, W'(k), 4'b1111);
         chk("stream_o1", 32'(o1), 32'(k));
         chk("stream_o_valid", 32'(o_valid), 32'b0010);
      end
      drive(1'b0, 2'd0, 4'b0000, 4'b1111);

      // random traffic
      for (int k = 0; k < 300; k++)
         drive(1'($urandom), 2'($urandom), W'($urandom), 4'($urandom));
      drive(1'b0, 2'd0, 4'b0000, 4'b1111);

      // reset between edges with two channels full
      drive(1'b1, 2'd0, 4'b0101, 4'b0000);
      drive(1'b1, 2'd3, 4'b1010, 4'b0000);
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_state("midreset");
      clear_model();
      #2;
      rst_n = 1'b1;
      check_ready_all_s("ready_after_midreset", 1'b1);
      @(posedge clk);
      #1;
      drive(1'b0, 2'd0, 4'b0000, 4'b0000);
      drive(1'b0, 2'd3, 4'b0000, 4'b0000);

`ifdef DEMUX_CNT_EN
      // counter wraps: 260 accepts leave 4; stalls do not count
      for (int k = 0; k < 260; k++)
         drive(1'b1, 2'(k % 4), W'(k), 4'b1111);
      chk("cnt_wrap", 32'(cnt), 32'd4);
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 2'd3, 4'b0111, 4'b0000);
         chk("cnt_stall", 32'(cnt), 32'd4);
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
